line_sequencer: RTL and testbench

Sits directly upstream of the line drawer and feeds it. Accepts line commands (two endpoints plus colour) through a valid/ready port and buffers them in a small FIFO. Drives the drawer's endpoint and reset inputs one line at a time, and turns the drawer's per-cycle x/y stream into qualified framebuffer pixel writes. Ends each line by step count, so a line is never cut short or overrun.

---
 rtl/line_pkg.sv | 33 +++
 rtl/line_cmd_fifo.sv | 60 ++++++
 rtl/line_sequencer.sv | 127 ++++++++++++
 tb/tb_line_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types and helpers for the line sequencer and its command FIFO.
package line_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned COLOR_W = 1;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] color;
  } line_cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW} seq_state_e;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Pixel count of a line: the major-axis span plus one; needs one extra bit.
  function automatic logic [COORD_W:0] line_steps(input line_cmd_t c);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] m;
    dx = abs_diff(c.x0, c.x1);
    dy = abs_diff(c.y0, c.y1);
    m  = (dx > dy) ? dx : dy;
    return {1'b0, m} + {{COORD_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Small synchronous FIFO of line commands; head is visible on rdata while non-empty.
module line_cmd_fifo
  import line_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  line_cmd_t wdata,
  input  logic      pop,
  output line_cmd_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  line_cmd_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              wr_en;
  logic              rd_en;

  // Qualify requests; a push while full is only accepted alongside a pop.
  always_comb begin
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !rd_en) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/line_sequencer.sv
// Buffers line commands, feeds the drawer one line at a time and qualifies its
// x/y stream into framebuffer writes, ending each line by step count.
module line_sequencer
  import line_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [COORD_W-1:0] ld_x0,
  output logic [COORD_W-1:0] ld_y0,
  output logic [COORD_W-1:0] ld_x1,
  output logic [COORD_W-1:0] ld_y1,
  output logic               ld_reset,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic [15:0]        lines_done
);

  seq_state_e       state_q, state_d;
  line_cmd_t        cur_q, cur_d;
  logic [COORD_W:0] steps_q, steps_d;
  logic [15:0]      lines_q, lines_d;
  logic             ready_q;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  line_cmd_t        fifo_head;
  line_cmd_t        fifo_wdata;

  assign fifo_wdata = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};

  line_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: pop in IDLE or on the final pixel, load the step count in LOAD.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    steps_d  = steps_q;
    lines_d  = lines_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        steps_d = line_steps(cur_q);
        state_d = DRAW;
      end
      DRAW: begin
        steps_d = steps_q - (COORD_W+1)'(1);
        if (steps_q == (COORD_W+1)'(1)) begin
          lines_d = lines_q + 16'd1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_head;
            state_d  = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; ready_q holds cmd_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      steps_q <= '0;
      lines_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      steps_q <= steps_d;
      lines_q <= lines_d;
      ready_q <= 1'b1;
    end
  end

  // Outputs decoded from the registered state so reset clears them immediately.
  always_comb begin
    cmd_ready  = ready_q && !fifo_full;
    ld_x0      = cur_q.x0;
    ld_y0      = cur_q.y0;
    ld_x1      = cur_q.x1;
    ld_y1      = cur_q.y1;
    ld_reset   = (state_q == LOAD);
    pix_valid  = (state_q == DRAW);
    pix_x      = ld_x;
    pix_y      = ld_y;
    pix_color  = cur_q.color;
    busy       = (state_q != IDLE) || !fifo_empty;
    lines_done = lines_q;
  end

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: models the downstream drawer and scoreboards every pixel.
module tb_line_sequencer;
  import line_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [COLOR_W-1:0] cmd_color = '0;
  logic [COORD_W-1:0] ld_x0, ld_y0, ld_x1, ld_y1;
  logic               ld_reset;
  logic [COORD_W-1:0] ld_x, ld_y;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               busy;
  logic [15:0]        lines_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  line_sequencer #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
    .ld_x0      (ld_x0),
    .ld_y0      (ld_y0),
    .ld_x1      (ld_x1),
    .ld_y1      (ld_y1),
    .ld_reset   (ld_reset),
    .ld_x       (ld_x),
    .ld_y       (ld_y),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .busy       (busy),
    .lines_done (lines_done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drawer stand-in: loads endpoints on ld_reset, then walks one Bresenham step per cycle.
  int dr_x = 0, dr_y = 0, dr_tx = 0, dr_ty = 0, dr_sx = 1, dr_sy = 1;
  int dr_dx = 0, dr_dy = 0, dr_err = 0;
  always @(posedge clk) begin : drawer
    int e2, nx, ny, ne, ddx, ddy;
    if (ld_reset) begin
      ddx = iabs(int'(ld_x1) - int'(ld_x0));
      ddy = -iabs(int'(ld_y1) - int'(ld_y0));
      dr_x   <= int'(ld_x0);
      dr_y   <= int'(ld_y0);
      dr_tx  <= int'(ld_x1);
      dr_ty  <= int'(ld_y1);
      dr_sx  <= (ld_x0 < ld_x1) ? 1 : -1;
      dr_sy  <= (ld_y0 < ld_y1) ? 1 : -1;
      dr_dx  <= ddx;
      dr_dy  <= ddy;
      dr_err <= ddx + ddy;
    end else if (!(dr_x == dr_tx && dr_y == dr_ty)) begin
      e2 = 2 * dr_err;
      nx = dr_x;
      ny = dr_y;
      ne = dr_err;
      if (e2 >= dr_dy) begin ne += dr_dy; nx += dr_sx; end
      if (e2 <= dr_dx) begin ne += dr_dx; ny += dr_sy; end
      dr_x   <= nx;
      dr_y   <= ny;
      dr_err <= ne;
    end
  end
  assign ld_x = COORD_W'(dr_x);
  assign ld_y = COORD_W'(dr_y);

  // Reference model: every accepted command appends its full pixel list, in order.
  logic [31:0] exp_q[$];
  int          lines_model = 0;

  task automatic add_expected(input int x0, input int y0, input int x1, input int y1,
                              input int c);
    int x = x0, y = y0, dx = iabs(x1 - x0), dy = -iabs(y1 - y0);
    int sx = (x0 < x1) ? 1 : -1, sy = (y0 < y1) ? 1 : -1, err = dx + dy, e2;
    forever begin
      exp_q.push_back(32'((x << 12) | (y << 1) | c));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Pixel monitor, sampled mid-cycle.
  int pix_cnt = 0, ldr_cnt = 0, first_cyc = -1, last_cyc = -1;
  int first_x = 0, first_y = 0, last_x = 0, last_y = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (ld_reset) ldr_cnt++;
      if (ld_reset || pix_valid) check("ld_reset_pix_excl", 32'(ld_reset & pix_valid), 32'd0);
      if (pix_valid) begin
        pix_cnt++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_x   = int'(pix_x);
          first_y   = int'(pix_y);
        end
        last_cyc = cyc;
        last_x   = int'(pix_x);
        last_y   = int'(pix_y);
        if (exp_q.size() == 0) check("unexpected_pixel", 32'(pix_valid), 32'd0);
        else check("pixel", {9'd0, pix_x, pix_y, pix_color}, exp_q.pop_front());
      end
    end
  end

  int hs_cyc = 0;

  // Offer a command until accepted (bounded), then drop valid.
  task automatic send(input int x0, input int y0, input int x1, input int y1, input int c);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_x0 = COORD_W'(x0); cmd_y0 = COORD_W'(y0);
    cmd_x1 = COORD_W'(x1); cmd_y1 = COORD_W'(y1);
    cmd_color = COLOR_W'(c);
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1 || n >= 5000) break;
      n++;
    end
    check("send_accepted", 32'(n < 5000), 32'd1);
    if (n < 5000) begin
      hs_cyc = cyc;
      add_expected(x0, y0, x1, y1, c);
      lines_model++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", 32'(n < limit), 32'd1);
  endtask

  initial begin
    int base, base_ldr, sum, gap;
    int rx0, ry0, rx1, ry1;

    // Reset state.
    #5;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ld_reset", 32'(ld_reset), 32'd0);
    check("rst_lines_done", 32'(lines_done), 32'd0);
    check("rst_ld_ends", {ld_x0, ld_y0, ld_x1[9:0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Horizontal line: latency and pixel count.
    base = pix_cnt; first_cyc = -1;
    send(10, 20, 15, 20, 1);
    wait_idle(200);
    check("horiz_latency", 32'(first_cyc - hs_cyc), 32'd3);
    check("horiz_pixels", 32'(pix_cnt - base), 32'd6);
    check("horiz_lines_done", 32'(lines_done), 32'd1);

    // Steep line.
    base = pix_cnt; base_ldr = ldr_cnt;
    send(5, 5, 7, 12, 0);
    wait_idle(200);
    check("steep_pixels", 32'(pix_cnt - base), 32'd8);
    check("steep_last", 32'((last_x << 16) | last_y), 32'((7 << 16) | 12));
    check("steep_ld_reset_cycles", 32'(ldr_cnt - base_ldr), 32'd1);

    // Degenerate line.
    base = pix_cnt;
    send(100, 100, 100, 100, 1);
    wait_idle(200);
    check("degen_pixels", 32'(pix_cnt - base), 32'd1);
    check("degen_busy", 32'(busy), 32'd0);

    // Back-to-back: one drawing plus four queued fills the FIFO.
    base = pix_cnt; first_cyc = -1;
    for (int k = 0; k < 5; k++) send(0, k, 19, k, k & 1);
    check("fifo_full_ready", 32'(cmd_ready), 32'd0);
    check("fifo_full_busy", 32'(busy), 32'd1);
    wait_idle(500);
    check("b2b_pixels", 32'(pix_cnt - base), 32'd100);
    check("b2b_span", 32'(last_cyc - first_cyc + 1), 32'd104);
    check("b2b_lines_done", 32'(lines_done), 32'(lines_model));

    // Reverse-direction long line.
    base = pix_cnt; first_cyc = -1;
    send(639, 479, 0, 0, 1);
    wait_idle(2000);
    check("rev_pixels", 32'(pix_cnt - base), 32'd640);
    check("rev_first", 32'((first_x << 16) | first_y), 32'((639 << 16) | 479));
    check("rev_last", 32'((last_x << 16) | last_y), 32'd0);
    check("rev_lines_done", 32'(lines_done), 32'(lines_model));

    // Reset during pixel 3 of a 50-pixel line with two commands queued.
    base = pix_cnt;
    send(0, 0, 49, 10, 1);
    send(1, 1, 5, 5, 0);
    send(2, 2, 8, 3, 1);
    begin
      int n = 0;
      while (pix_cnt < base + 3 && n < 200) begin @(negedge clk); n++; end
      check("reach_pixel3", 32'(pix_cnt - base), 32'd3);
    end
    reset = 1'b0;
    #1;
    check("midrst_pix_valid", 32'(pix_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_lines_done", 32'(lines_done), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    lines_model = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("postrst_no_pixels", 32'(pix_cnt - base), 32'd3);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomized lines with random gaps between offers.
    base = pix_cnt; sum = 0;
    for (int k = 0; k < 16; k++) begin
      rx0 = int'($urandom_range(0, 63)); ry0 = int'($urandom_range(0, 63));
      rx1 = int'($urandom_range(0, 63)); ry1 = int'($urandom_range(0, 63));
      sum += ((iabs(rx1 - rx0) > iabs(ry1 - ry0)) ? iabs(rx1 - rx0) : iabs(ry1 - ry0)) + 1;
      send(rx0, ry0, rx1, ry1, int'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      #1;
    end
    wait_idle(3000);
    check("rand_pixels", 32'(pix_cnt - base), 32'(sum));
    check("rand_lines_done", 32'(lines_done), 32'(lines_model));
    check("rand_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
